// File: rtl/ps_ureg_pkg.sv
// ps_ureg_pkg: shared constants for the program-sequencer ureg bank.
// Holds local register addresses, STKY bit positions and the default width.
package ps_ureg_pkg;

  localparam int PS_DATA_W = 16;

  // Local 5-bit addresses inside groups 0110/0111
  localparam logic [4:0] PS_IDLE   = 5'h00;
  localparam logic [4:0] PS_FADDR  = 5'h01;
  localparam logic [4:0] PS_PCSTK  = 5'h04;
  localparam logic [4:0] PS_PCSTKP = 5'h05;
  localparam logic [4:0] PS_LADDR  = 5'h06;
  localparam logic [4:0] PS_LCNTR  = 5'h08;
  localparam logic [4:0] PS_MODE1  = 5'h11;
  localparam logic [4:0] PS_STKY   = 5'h13;

  // Sticky status bits
  localparam int STKY_W   = 2;
  localparam int STKY_OVF = 0;
  localparam int STKY_UNF = 1;

  // Sticky update: a set event in the same cycle as a clear keeps the bit set
  function automatic logic [STKY_W-1:0] stky_next(
    input logic [STKY_W-1:0] cur,
    input logic [STKY_W-1:0] set,
    input logic [STKY_W-1:0] clr
  );
    return (cur & ~clr) | set;
  endfunction

endpackage

// File: rtl/ps_pc_stack.sv
// ps_pc_stack: PC-stack LIFO with push, pop and same-cycle replace-top.
// Produces single-cycle overflow/underflow pulses for the sticky register.
module ps_pc_stack
  import ps_ureg_pkg::*;
#(
  parameter int DATA_W    = PS_DATA_W,
  parameter int STK_DEPTH = 8,
  parameter int PTR_W     = $clog2(STK_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_top,
  output logic [PTR_W-1:0]  o_ptr,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_ovf,
  output logic              o_unf
);

  localparam int IDX_W = $clog2(STK_DEPTH);

  logic [DATA_W-1:0] r_mem [STK_DEPTH];
  logic [PTR_W-1:0]  r_ptr;

  logic [PTR_W-1:0]  w_ptr_m1;
  logic [PTR_W-1:0]  w_ptr_p1;
  logic [IDX_W-1:0]  w_top_idx;
  logic              w_empty;
  logic              w_full;
  logic              w_wr_en;
  logic [IDX_W-1:0]  w_wr_idx;
  logic [PTR_W-1:0]  w_ptr_nxt;
  logic              w_ovf;
  logic              w_unf;

  assign w_ptr_m1  = r_ptr - {{(PTR_W-1){1'b0}}, 1'b1};
  assign w_ptr_p1  = r_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
  // When full, ptr-1 low bits still address the last entry correctly
  assign w_top_idx = w_ptr_m1[IDX_W-1:0];
  assign w_empty   = (r_ptr == {PTR_W{1'b0}});
  assign w_full    = (r_ptr == PTR_W'(STK_DEPTH));

  // Next-state decode for push / pop / replace-top and status pulses
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_idx  = r_ptr[IDX_W-1:0];
    w_ptr_nxt = r_ptr;
    w_ovf     = 1'b0;
    w_unf     = 1'b0;
    case ({i_push, i_pop})
      2'b10: begin
        if (w_full) begin
          w_ovf = 1'b1;
        end else begin
          w_wr_en   = 1'b1;
          w_ptr_nxt = w_ptr_p1;
        end
      end
      2'b01: begin
        if (w_empty) begin
          w_unf = 1'b1;
        end else begin
          w_ptr_nxt = w_ptr_m1;
        end
      end
      2'b11: begin
        if (w_empty) begin
          // Nothing to replace: the push lands, the pop is an underflow
          w_wr_en   = 1'b1;
          w_ptr_nxt = w_ptr_p1;
          w_unf     = 1'b1;
        end else begin
          w_wr_en  = 1'b1;
          w_wr_idx = w_top_idx;
        end
      end
      default: begin
        w_wr_en = 1'b0;
      end
    endcase
  end

  // Stack pointer and entry storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= {PTR_W{1'b0}};
      for (int i = 0; i < STK_DEPTH; i++) begin
        r_mem[i] <= {DATA_W{1'b0}};
      end
    end else begin
      r_ptr <= w_ptr_nxt;
      if (w_wr_en) begin
        r_mem[w_wr_idx] <= i_data;
      end
    end
  end

  assign o_top   = w_empty ? {DATA_W{1'b0}} : r_mem[w_top_idx];
  assign o_ptr   = r_ptr;
  assign o_empty = w_empty;
  assign o_full  = w_full;
  assign o_ovf   = w_ovf;
  assign o_unf   = w_unf;

endmodule

// File: rtl/ps_ureg_bank.sv
// ps_ureg_bank: sequencer universal-register bank (responder side).
// Decodes local write addresses, holds LADDR/LCNTR/MODE1/STKY, owns the
// PC stack and drives the combinational read mux onto the ureg bus.
module ps_ureg_bank
  import ps_ureg_pkg::*;
#(
  parameter int DATA_W    = PS_DATA_W,
  parameter int STK_DEPTH = 8,
  parameter int PTR_W     = $clog2(STK_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ps_wrt_en,
  input  logic [4:0]        ps_wrt_add,
  input  logic [DATA_W-1:0] ps_wrt_data,
  input  logic [4:0]        ps_rd_add,
  output logic [DATA_W-1:0] ps_rd_data,
  input  logic              ps_stk_pop,
  input  logic              ps_lcntr_dec,
  input  logic [DATA_W-1:0] ps_faddr_in,
  output logic [DATA_W-1:0] ps_pcstk_top,
  output logic              ps_stk_empty,
  output logic              ps_stk_full,
  output logic              ps_lcntr_zero,
  output logic [DATA_W-1:0] ps_mode1
);

  logic [DATA_W-1:0] r_laddr;
  logic [DATA_W-1:0] r_lcntr;
  logic [DATA_W-1:0] r_mode1;
  logic [STKY_W-1:0] r_stky;

  logic              w_wr_pcstk;
  logic              w_wr_laddr;
  logic              w_wr_lcntr;
  logic              w_wr_mode1;
  logic              w_wr_stky;
  logic [DATA_W-1:0] w_top;
  logic [PTR_W-1:0]  w_ptr;
  logic              w_ovf;
  logic              w_unf;
  logic              w_lcntr_zero;
  logic [STKY_W-1:0] w_stky_set;
  logic [STKY_W-1:0] w_stky_clr;

  assign w_wr_pcstk = ps_wrt_en & (ps_wrt_add == PS_PCSTK);
  assign w_wr_laddr = ps_wrt_en & (ps_wrt_add == PS_LADDR);
  assign w_wr_lcntr = ps_wrt_en & (ps_wrt_add == PS_LCNTR);
  assign w_wr_mode1 = ps_wrt_en & (ps_wrt_add == PS_MODE1);
  assign w_wr_stky  = ps_wrt_en & (ps_wrt_add == PS_STKY);

  ps_pc_stack #(
    .DATA_W    (DATA_W),
    .STK_DEPTH (STK_DEPTH),
    .PTR_W     (PTR_W)
  ) u_pc_stack (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_wr_pcstk),
    .i_pop   (ps_stk_pop),
    .i_data  (ps_wrt_data),
    .o_top   (w_top),
    .o_ptr   (w_ptr),
    .o_empty (ps_stk_empty),
    .o_full  (ps_stk_full),
    .o_ovf   (w_ovf),
    .o_unf   (w_unf)
  );

  assign w_lcntr_zero = (r_lcntr == {DATA_W{1'b0}});

  assign w_stky_set = {w_unf, w_ovf};
  assign w_stky_clr = w_wr_stky ? ps_wrt_data[STKY_W-1:0] : {STKY_W{1'b0}};

  // Loop address and MODE1 are plain load registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_laddr <= {DATA_W{1'b0}};
      r_mode1 <= {DATA_W{1'b0}};
    end else begin
      if (w_wr_laddr) begin
        r_laddr <= ps_wrt_data;
      end
      if (w_wr_mode1) begin
        r_mode1 <= ps_wrt_data;
      end
    end
  end

  // Loop counter: a write beats a decrement; decrement saturates at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lcntr <= {DATA_W{1'b0}};
    end else if (w_wr_lcntr) begin
      r_lcntr <= ps_wrt_data;
    end else if (ps_lcntr_dec && !w_lcntr_zero) begin
      r_lcntr <= r_lcntr - {{(DATA_W-1){1'b0}}, 1'b1};
    end else begin
      r_lcntr <= r_lcntr;
    end
  end

  // Sticky overflow/underflow flags, write-1-to-clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stky <= {STKY_W{1'b0}};
    end else begin
      r_stky <= stky_next(r_stky, w_stky_set, w_stky_clr);
    end
  end

  // Combinational read mux over the local address map
  always_comb begin
    ps_rd_data = {DATA_W{1'b0}};
    case (ps_rd_add)
      PS_FADDR:  ps_rd_data = ps_faddr_in;
      PS_PCSTK:  ps_rd_data = w_top;
      PS_PCSTKP: ps_rd_data = {{(DATA_W-PTR_W){1'b0}}, w_ptr};
      PS_LADDR:  ps_rd_data = r_laddr;
      PS_LCNTR:  ps_rd_data = r_lcntr;
      PS_MODE1:  ps_rd_data = r_mode1;
      PS_STKY:   ps_rd_data = {{(DATA_W-STKY_W){1'b0}}, r_stky};
      default:   ps_rd_data = {DATA_W{1'b0}};
    endcase
  end

  assign ps_pcstk_top  = w_top;
  assign ps_lcntr_zero = w_lcntr_zero;
  assign ps_mode1      = r_mode1;

endmodule

// File: tb/tb_ps_ureg_bank.sv
// tb_ps_ureg_bank: directed self-checking bench for ps_ureg_bank.
module tb_ps_ureg_bank;
  import ps_ureg_pkg::*;

  logic        clk;
  logic        rst;
  logic        ps_wrt_en;
  logic [4:0]  ps_wrt_add;
  logic [15:0] ps_wrt_data;
  logic [4:0]  ps_rd_add;
  logic [15:0] ps_rd_data;
  logic        ps_stk_pop;
  logic        ps_lcntr_dec;
  logic [15:0] ps_faddr_in;
  logic [15:0] ps_pcstk_top;
  logic        ps_stk_empty;
  logic        ps_stk_full;
  logic        ps_lcntr_zero;
  logic [15:0] ps_mode1;

  int n_chk = 0;
  int n_err = 0;

  ps_ureg_bank #(.DATA_W(16), .STK_DEPTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .ps_wrt_en     (ps_wrt_en),
    .ps_wrt_add    (ps_wrt_add),
    .ps_wrt_data   (ps_wrt_data),
    .ps_rd_add     (ps_rd_add),
    .ps_rd_data    (ps_rd_data),
    .ps_stk_pop    (ps_stk_pop),
    .ps_lcntr_dec  (ps_lcntr_dec),
    .ps_faddr_in   (ps_faddr_in),
    .ps_pcstk_top  (ps_pcstk_top),
    .ps_stk_empty  (ps_stk_empty),
    .ps_stk_full   (ps_stk_full),
    .ps_lcntr_zero (ps_lcntr_zero),
    .ps_mode1      (ps_mode1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input logic [4:0] addr, input logic [15:0] exp);
    ps_rd_add = addr;
    #1;
    chk(tag, ps_rd_data, exp);
  endtask

  // Advance one edge, then drop all single-cycle strobes
  task automatic cyc();
    @(posedge clk);
    #1;
    ps_wrt_en    = 1'b0;
    ps_stk_pop   = 1'b0;
    ps_lcntr_dec = 1'b0;
  endtask

  task automatic wr(input logic [4:0] addr, input logic [15:0] data);
    ps_wrt_en   = 1'b1;
    ps_wrt_add  = addr;
    ps_wrt_data = data;
    cyc();
  endtask

  initial begin
    logic [4:0]  addrs [9];
    logic [15:0] exps  [9];
    addrs = '{PS_IDLE, PS_FADDR, PS_PCSTK, PS_PCSTKP, PS_LADDR, PS_LCNTR, PS_MODE1, PS_STKY, 5'h1F};
    exps  = '{16'h0000, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};

    rst = 1'b1; ps_wrt_en = 1'b0; ps_wrt_add = 5'h00; ps_wrt_data = 16'h0000;
    ps_rd_add = 5'h00; ps_stk_pop = 1'b0; ps_lcntr_dec = 1'b0; ps_faddr_in = 16'h1234;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    for (int i = 0; i < 9; i++) chk_rd($sformatf("rst_rd_%0h", addrs[i]), addrs[i], exps[i]);
    chk("rst_empty", {15'd0, ps_stk_empty}, 16'd1);
    chk("rst_full", {15'd0, ps_stk_full}, 16'd0);
    chk("rst_lzero", {15'd0, ps_lcntr_zero}, 16'd1);
    chk("rst_top", ps_pcstk_top, 16'h0000);
    chk("rst_mode1", ps_mode1, 16'h0000);

    // Write to unmapped and read-only addresses is ignored
    wr(5'h1F, 16'hFFFF);
    wr(PS_PCSTKP, 16'h0007);
    chk_rd("unmapped_wr", 5'h1F, 16'h0000);
    chk_rd("ro_ptr_wr", PS_PCSTKP, 16'h0000);

    // Three pushes then three pops
    wr(PS_PCSTK, 16'hA001);
    wr(PS_PCSTK, 16'hA002);
    wr(PS_PCSTK, 16'hA003);
    chk_rd("ptr3", PS_PCSTKP, 16'h0003);
    chk("top3", ps_pcstk_top, 16'hA003);
    ps_stk_pop = 1'b1; chk_rd("pop_a003", PS_PCSTK, 16'hA003); cyc();
    ps_stk_pop = 1'b1; chk_rd("pop_a002", PS_PCSTK, 16'hA002); cyc();
    ps_stk_pop = 1'b1; chk_rd("pop_a001", PS_PCSTK, 16'hA001); cyc();
    chk("empty_after_pops", {15'd0, ps_stk_empty}, 16'd1);
    chk_rd("stky_clean", PS_STKY, 16'h0000);

    // Overflow: nine pushes into eight entries
    for (int i = 0; i < 9; i++) wr(PS_PCSTK, 16'hB000 + 16'(i));
    chk_rd("ptr_full", PS_PCSTKP, 16'h0008);
    chk("full_flag", {15'd0, ps_stk_full}, 16'd1);
    chk("top_full", ps_pcstk_top, 16'hB007);
    chk_rd("stky_ovf", PS_STKY, 16'h0001);
    for (int i = 7; i >= 0; i--) begin
      ps_stk_pop = 1'b1;
      chk_rd($sformatf("drain_%0d", i), PS_PCSTK, 16'hB000 + 16'(i));
      cyc();
    end
    // Underflow: pop when empty reads 0
    ps_stk_pop = 1'b1; chk_rd("pop_empty_rd", PS_PCSTK, 16'h0000); cyc();
    chk_rd("ptr_held0", PS_PCSTKP, 16'h0000);
    chk_rd("stky_both", PS_STKY, 16'h0003);
    wr(PS_STKY, 16'h0001);
    chk_rd("stky_w1c", PS_STKY, 16'h0002);
    // Clear of bit1 coinciding with another underflow: set wins
    ps_stk_pop = 1'b1; wr(PS_STKY, 16'h0002);
    chk_rd("stky_set_wins", PS_STKY, 16'h0002);
    wr(PS_STKY, 16'h0003);
    chk_rd("stky_cleared", PS_STKY, 16'h0000);

    // Replace-top: push and pop together on a non-empty stack
    wr(PS_PCSTK, 16'h00B1);
    wr(PS_PCSTK, 16'h00B2);
    ps_stk_pop = 1'b1; wr(PS_PCSTK, 16'h00C7);
    chk_rd("repl_ptr", PS_PCSTKP, 16'h0002);
    chk("repl_top", ps_pcstk_top, 16'h00C7);
    ps_stk_pop = 1'b1; cyc();
    chk("repl_under", ps_pcstk_top, 16'h00B1);
    ps_stk_pop = 1'b1; cyc();
    // Push and pop together on an empty stack
    ps_stk_pop = 1'b1; wr(PS_PCSTK, 16'h00D5);
    chk_rd("pp_empty_ptr", PS_PCSTKP, 16'h0001);
    chk("pp_empty_top", ps_pcstk_top, 16'h00D5);
    chk_rd("pp_empty_stky", PS_STKY, 16'h0002);

    // Loop counter
    wr(PS_LCNTR, 16'h0003);
    chk("lc_nz", {15'd0, ps_lcntr_zero}, 16'd0);
    ps_lcntr_dec = 1'b1; cyc(); chk_rd("lc_2", PS_LCNTR, 16'h0002);
    ps_lcntr_dec = 1'b1; cyc(); chk_rd("lc_1", PS_LCNTR, 16'h0001);
    chk("lc_nz1", {15'd0, ps_lcntr_zero}, 16'd0);
    ps_lcntr_dec = 1'b1; cyc(); chk_rd("lc_0", PS_LCNTR, 16'h0000);
    chk("lc_z", {15'd0, ps_lcntr_zero}, 16'd1);
    ps_lcntr_dec = 1'b1; cyc(); chk_rd("lc_sat", PS_LCNTR, 16'h0000);
    ps_lcntr_dec = 1'b1; wr(PS_LCNTR, 16'h0005);
    chk_rd("lc_wr_wins", PS_LCNTR, 16'h0005);

    // LADDR and MODE1, with read-during-write returning the old value
    wr(PS_LADDR, 16'h1357);
    chk_rd("laddr", PS_LADDR, 16'h1357);
    ps_wrt_en = 1'b1; ps_wrt_add = PS_MODE1; ps_wrt_data = 16'h00FF;
    chk_rd("mode1_old", PS_MODE1, 16'h0000);
    cyc();
    chk_rd("mode1_new", PS_MODE1, 16'h00FF);
    chk("mode1_port", ps_mode1, 16'h00FF);

    // Asynchronous reset in the middle of a push
    ps_wrt_en = 1'b1; ps_wrt_add = PS_PCSTK; ps_wrt_data = 16'hEE02; ps_stk_pop = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("ar_empty", {15'd0, ps_stk_empty}, 16'd1);
    chk("ar_top", ps_pcstk_top, 16'h0000);
    chk("ar_mode1", ps_mode1, 16'h0000);
    chk("ar_lzero", {15'd0, ps_lcntr_zero}, 16'd1);
    chk_rd("ar_laddr", PS_LADDR, 16'h0000);
    chk_rd("ar_stky", PS_STKY, 16'h0000);
    chk_rd("ar_ptr", PS_PCSTKP, 16'h0000);
    cyc();
    chk_rd("ar_hold_ptr", PS_PCSTKP, 16'h0000);
    rst = 1'b0;
    #1;
    chk_rd("ar_faddr", PS_FADDR, 16'h1234);
    chk("ar_empty2", {15'd0, ps_stk_empty}, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
